// File: rtl/singleport_mem_ctrl.sv
// singleport_mem_ctrl: host-side sequencer for a single-port block RAM with a
// shared bidirectional data bus. It accepts one command per handshake, drives
// the RAM strobes and address, and owns its half of the tristate bus. After
// every read it inserts a turnaround cycle so that the two bus drivers never
// overlap.
//
// Handshake: a command transfers at a rising edge where i_cmd_valid and
// o_cmd_ready are both 1. o_cmd_ready is decoded from the state alone and never
// depends on i_cmd_valid. The host keeps i_cmd_valid and the command fields
// steady until the transfer happens. o_rvalid is a one-cycle pulse with no
// back-pressure.
module singleport_mem_ctrl #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic              i_cmd_write,
  input  logic [ADDR_W-1:0] i_cmd_addr,
  input  logic [DATA_W-1:0] i_cmd_wdata,
  output logic              o_rvalid,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_mem_read,
  output logic              o_mem_write,
  output logic [ADDR_W-1:0] o_mem_addr,
  inout  wire  [DATA_W-1:0] io_mem_data,
  output logic [2:0]        o_dbg_state
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    RD   = 3'd2,
    CAP  = 3'd3,
    TURN = 3'd4
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              rvalid_q;
  logic              accept;

  assign accept = i_cmd_valid & o_cmd_ready;

  // State register; reset returns to IDLE, which also releases the bus.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and ready decode. Ready depends only on the state.
  always_comb begin
    state_nxt   = state;
    o_cmd_ready = 1'b0;
    case (state)
      IDLE: begin
        o_cmd_ready = 1'b1;
        if (i_cmd_valid) begin
          state_nxt = i_cmd_write ? WR : RD;
        end
      end
      WR: begin
        o_cmd_ready = 1'b1;
        if (i_cmd_valid) begin
          state_nxt = i_cmd_write ? WR : RD;
        end else begin
          state_nxt = IDLE;
        end
      end
      RD:      state_nxt = CAP;
      CAP:     state_nxt = TURN;
      TURN:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Command capture. The address changes only on accept, so it holds through
  // IDLE, CAP and TURN. Write data is captured only by write commands.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      addr_q <= i_cmd_addr;
      if (i_cmd_write) begin
        wdata_q <= i_cmd_wdata;
      end
    end
  end

  // Read return. The RAM drives the bus during CAP, so the bus is sampled at the
  // edge that ends CAP. The valid pulse therefore lines up with TURN. A reset
  // during RD or CAP clears both registers, which discards the read.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= (state == CAP);
      if (state == CAP) begin
        rdata_q <= io_mem_data;
      end
    end
  end

  assign o_mem_write = (state == WR);
  assign o_mem_read  = (state == RD);
  assign o_mem_addr  = addr_q;
  assign o_rvalid    = rvalid_q;
  assign o_rdata     = rdata_q;
  assign o_dbg_state = state;

  // The controller drives the bus only in WR and releases it in every other state.
  assign io_mem_data = (state == WR) ? wdata_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_singleport_mem_ctrl.sv
// Directed testbench for singleport_mem_ctrl. A small behavioural single-port RAM
// sits on the shared bus. The RAM drives the bus for one cycle after a read
// strobe and captures the bus on a write strobe.
module tb_singleport_mem_ctrl;
  localparam int AW = 10;
  localparam int DW = 16;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WR   = 3'd1;
  localparam logic [2:0] S_RD   = 3'd2;
  localparam logic [2:0] S_CAP  = 3'd3;
  localparam logic [2:0] S_TURN = 3'd4;

  logic          clk;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rvalid;
  logic [DW-1:0] rdata;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  wire  [DW-1:0] mem_bus;
  logic [2:0]    dbg_state;

  int total = 0;
  int bad   = 0;
  logic mon_en = 1'b0;

  // Behavioural RAM model
  logic [DW-1:0] ram [0:(1<<AW)-1];
  logic          ram_drive = 1'b0;
  logic [DW-1:0] ram_q = '0;

  assign mem_bus = ram_drive ? ram_q : {DW{1'bz}};

  // The RAM commits writes at the edge that ends WR. It drives read data during
  // the cycle after its read strobe.
  always @(posedge clk) begin
    if (mem_write) ram[mem_addr] <= mem_bus;
    ram_drive <= mem_read;
    if (mem_read) ram_q <= ram[mem_addr];
  end

  singleport_mem_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_cmd_valid (cmd_valid),
    .o_cmd_ready (cmd_ready),
    .i_cmd_write (cmd_write),
    .i_cmd_addr  (cmd_addr),
    .i_cmd_wdata (cmd_wdata),
    .o_rvalid    (rvalid),
    .o_rdata     (rdata),
    .o_mem_read  (mem_read),
    .o_mem_write (mem_write),
    .o_mem_addr  (mem_addr),
    .io_mem_data (mem_bus),
    .o_dbg_state (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // True when nobody drives the bus. A 2-state simulator reads an undriven bus as 0.
  function automatic logic bus_free();
    return (mem_bus === {DW{1'bz}}) || (mem_bus === {DW{1'b0}});
  endfunction

  // Only one side may drive the bus in any cycle.
  always @(negedge clk) begin
    if (mon_en) check("bus_contention", {31'b0, mem_write & ram_drive}, 32'd0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = a; cmd_wdata = d;
    check("wr_ready_pre", {31'b0, cmd_ready}, 32'd1);
    tick();
    check("wr_state", {29'b0, dbg_state}, {29'b0, S_WR});
    check("wr_strobe", {31'b0, mem_write}, 32'd1);
    check("wr_addr", {22'b0, mem_addr}, {22'b0, a});
    check("wr_bus", {16'b0, mem_bus}, {16'b0, d});
    cmd_valid = 1'b0;
    tick();
    check("wr_done", {31'b0, mem_write}, 32'd0);
  endtask

  // Walks one read through RD, CAP and TURN, checking each cycle.
  task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] exp);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = a;
    check("rd_ready_pre", {31'b0, cmd_ready}, 32'd1);
    tick();
    check("rd_state", {29'b0, dbg_state}, {29'b0, S_RD});
    check("rd_strobe", {31'b0, mem_read}, 32'd1);
    check("rd_addr", {22'b0, mem_addr}, {22'b0, a});
    check("rd_ready", {31'b0, cmd_ready}, 32'd0);
    check("rd_bus_free", {31'b0, bus_free()}, 32'd1);
    check("rd_rvalid", {31'b0, rvalid}, 32'd0);
    cmd_valid = 1'b0;
    tick();
    check("cap_state", {29'b0, dbg_state}, {29'b0, S_CAP});
    check("cap_strobe", {31'b0, mem_read}, 32'd0);
    check("cap_ready", {31'b0, cmd_ready}, 32'd0);
    check("cap_bus", {16'b0, mem_bus}, {16'b0, exp});
    check("cap_rvalid", {31'b0, rvalid}, 32'd0);
    tick();
    check("turn_rvalid", {31'b0, rvalid}, 32'd1);
    check("turn_rdata", {16'b0, rdata}, {16'b0, exp});
    check("turn_ready", {31'b0, cmd_ready}, 32'd0);
    check("turn_bus_free", {31'b0, bus_free()}, 32'd1);
    tick();
    check("post_rvalid", {31'b0, rvalid}, 32'd0);
    check("post_rdata_hold", {16'b0, rdata}, {16'b0, exp});
    check("post_ready", {31'b0, cmd_ready}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 10'h005; cmd_wdata = 16'hFFFF;
    ram[10'h3FF] = 16'hBEEF;

    // Reset: a pending write is ignored while reset is held.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_write", {31'b0, mem_write}, 32'd0);
      check("rst_read", {31'b0, mem_read}, 32'd0);
    end
    check("rst_state", {29'b0, dbg_state}, {29'b0, S_IDLE});
    check("rst_addr", {22'b0, mem_addr}, 32'd0);
    check("rst_rvalid", {31'b0, rvalid}, 32'd0);
    check("rst_rdata", {16'b0, rdata}, 32'd0);
    check("rst_ready", {31'b0, cmd_ready}, 32'd1);
    cmd_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    check("rel_state", {29'b0, dbg_state}, {29'b0, S_IDLE});
    check("rel_ready", {31'b0, cmd_ready}, 32'd1);
    mon_en = 1'b1;

    // Single write, then read it back.
    do_write(10'h005, 16'hA5A5);
    do_read(10'h005, 16'hA5A5);

    // Back-to-back writes with valid held high for four cycles.
    for (int i = 0; i < 4; i++) begin
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = AW'(i); cmd_wdata = DW'((i + 1) * 16'h1111);
      check("b2b_ready", {31'b0, cmd_ready}, 32'd1);
      tick();
      check("b2b_strobe", {31'b0, mem_write}, 32'd1);
      check("b2b_bus", {16'b0, mem_bus}, {16'b0, DW'((i + 1) * 16'h1111)});
    end
    cmd_valid = 1'b0;
    tick();
    check("b2b_done", {31'b0, mem_write}, 32'd0);
    do_read(10'h000, 16'h1111);
    do_read(10'h001, 16'h2222);
    do_read(10'h002, 16'h3333);
    do_read(10'h003, 16'h4444);

    // Read, then a write held pending behind it.
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 10'h3FF;
    tick();
    check("rw_rd_state", {29'b0, dbg_state}, {29'b0, S_RD});
    cmd_write = 1'b1; cmd_wdata = 16'h0001;
    tick();
    check("rw_cap_ready", {31'b0, cmd_ready}, 32'd0);
    check("rw_cap_write", {31'b0, mem_write}, 32'd0);
    tick();
    check("rw_turn_ready", {31'b0, cmd_ready}, 32'd0);
    check("rw_turn_write", {31'b0, mem_write}, 32'd0);
    check("rw_turn_rvalid", {31'b0, rvalid}, 32'd1);
    check("rw_turn_rdata", {16'b0, rdata}, 32'h0000BEEF);
    tick();
    check("rw_idle_state", {29'b0, dbg_state}, {29'b0, S_IDLE});
    check("rw_idle_write", {31'b0, mem_write}, 32'd0);
    check("rw_idle_ready", {31'b0, cmd_ready}, 32'd1);
    tick();
    check("rw_wr_strobe", {31'b0, mem_write}, 32'd1);
    check("rw_wr_bus", {16'b0, mem_bus}, 32'h00000001);
    cmd_valid = 1'b0;
    tick();
    do_read(10'h3FF, 16'h0001);

    // Write followed directly by a read of the same address (WR to RD).
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 10'h200; cmd_wdata = 16'h1234;
    tick();
    check("wrd_wr_state", {29'b0, dbg_state}, {29'b0, S_WR});
    cmd_write = 1'b0;
    tick();
    check("wrd_rd_state", {29'b0, dbg_state}, {29'b0, S_RD});
    check("wrd_rd_addr", {22'b0, mem_addr}, 32'h200);
    cmd_valid = 1'b0;
    tick();
    check("wrd_cap_bus", {16'b0, mem_bus}, 32'h00001234);
    tick();
    check("wrd_rvalid", {31'b0, rvalid}, 32'd1);
    check("wrd_rdata", {16'b0, rdata}, 32'h00001234);
    tick();

    // Reset asserted during CAP discards the read.
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 10'h005;
    tick();
    cmd_valid = 1'b0;
    tick();
    check("rc_cap_state", {29'b0, dbg_state}, {29'b0, S_CAP});
    rst_n = 1'b0;
    tick();
    check("rc_state", {29'b0, dbg_state}, {29'b0, S_IDLE});
    check("rc_rvalid", {31'b0, rvalid}, 32'd0);
    check("rc_rdata", {16'b0, rdata}, 32'd0);
    rst_n = 1'b1;
    tick();
    check("rc_rvalid_after", {31'b0, rvalid}, 32'd0);
    do_read(10'h001, 16'h2222);
    do_write(10'h010, 16'h5A5A);
    do_read(10'h010, 16'h5A5A);

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/singleport_mem_ctrl.md
Name: singleport_mem_ctrl

Overview:
- Host-side controller that sits directly upstream of the team's single-port 1Kx16 block RAM.
- It accepts read and write commands on a valid/ready interface.
- It sequences the RAM's read/write strobes and address, owns its side of the shared bidirectional data bus (tristate enable), and enforces bus turnaround.
- It returns read data with a one-cycle valid pulse.

Parameters:
- ADDR_W, 10, RAM address width
- DATA_W, 16, data / bus width

Ports:
- i_clk  in  1  clock, all logic on rising edge
- i_rst_n  in  1  synchronous active-low reset
- i_cmd_valid  in  1  command present
- o_cmd_ready  out  1  controller can accept a command this cycle
- i_cmd_write  in  1  1 = write, 0 = read; sampled on accept
- i_cmd_addr  in  ADDR_W  command address; sampled on accept
- i_cmd_wdata  in  DATA_W  write data; sampled on accept
- o_rvalid  out  1  read data valid, single-cycle pulse
- o_rdata  out  DATA_W  read data, held until next read completes
- o_mem_read  out  1  to RAM read strobe
- o_mem_write  out  1  to RAM write strobe
- o_mem_addr  out  ADDR_W  to RAM address
- io_mem_data  inout  DATA_W  shared RAM data bus; driven only in WR state, else high-Z

Behaviour:
- Reset and clocking:
  - Single clock. Reset is synchronous and active-low.
  - While i_rst_n=0 at an edge: state=IDLE; o_mem_read=0, o_mem_write=0, o_mem_addr=0, o_rvalid=0, o_rdata=0; bus released to Z.
- Accept rule:
  - A command is accepted at a rising edge where i_cmd_valid and o_cmd_ready are both 1.
  - addr and wdata are captured at that edge. A valid without ready is held by the host (no drop, no change required of the controller).
  - o_cmd_ready = 1 in IDLE and WR, 0 in RD, CAP, TURN. It is a combinational decode of state only; it never depends on i_cmd_valid.
- FSM (Moore; all RAM-side outputs decoded from the state/address/data registers only, no input-to-output paths):
  - IDLE: strobes 0, bus Z. On accept of a write -> WR; on accept of a read -> RD.
  - WR: o_mem_write=1, o_mem_addr=captured addr, io_mem_data driven with captured wdata. The RAM commits at the edge ending WR. On accept of a write -> WR (back-to-back, one write per cycle); on accept of a read -> RD; else -> IDLE.
  - RD: o_mem_read=1, o_mem_addr=captured addr, bus Z. Always -> CAP.
  - CAP: strobes 0, bus Z; the RAM drives io_mem_data. At the edge ending CAP: o_rdata <= io_mem_data, o_rvalid <= 1. Always -> TURN.
  - TURN: o_rvalid=1 (the only cycle it is high), bus Z; the RAM has released the bus. Always -> IDLE.
- Latencies:
  - Write: strobe in the first cycle after accept.
  - Read: o_rvalid is high in the 3rd cycle after the accept edge. Peak read rate is 1 per 4 cycles.
- Bus rules:
  - The controller never drives io_mem_data in RD, CAP or TURN.
  - A write can never follow a read with less than one full Z cycle (TURN) after the RAM's drive cycle (CAP).
  - WR -> RD is allowed directly: the RAM does not drive until CAP.
- Address/data hold: o_mem_addr holds its last value in IDLE/CAP/TURN. Write data register holds its last value.
- o_rdata is updated only at the CAP->TURN edge.
- Reset mid-operation:
  - A WR cycle whose ending edge coincides with reset still commits (the RAM samples the same edge).
  - Reset during RD/CAP abandons the read: no o_rvalid, o_rdata = 0.
  - The controller bus is Z from the reset edge onward.
- Simultaneous events:
  - i_cmd_valid in RD/CAP/TURN is ignored (ready=0).
  - i_cmd_valid in the same cycle as reset deassertion is not accepted: state is IDLE only after the first edge with i_rst_n=1 … ready is high from that edge.

Test Plan:
- Reset: hold i_rst_n=0 for 3 edges with i_cmd_valid=1 -> all outputs 0, bus Z, o_cmd_ready=1 after release, no strobe issued.
- Single write then read: write addr 0x005 data 0xA5A5, then read 0x005 -> o_mem_write high 1 cycle with bus=0xA5A5. o_rvalid pulses once in the 3rd cycle after read accept with o_rdata=0xA5A5. Bus Z in RD/CAP/TURN.
- Back-to-back writes: i_cmd_valid held 4 cycles, addrs 0x000..0x003, data 0x1111..0x4444 -> o_mem_write high 4 consecutive cycles, ready never drops. Readback returns 0x1111, 0x2222, 0x3333, 0x4444.
- Read then immediate write: read 0x3FF (preloaded 0xBEEF) with write 0x3FF/0x0001 pending -> ready low RD/CAP/TURN, rdata=0xBEEF. Write strobe no earlier than the cycle after TURN, and the bus is never driven by both sides (no X on io_mem_data).
- Write then immediate read of same address 0x200/0x1234 -> WR->RD direct, read returns 0x1234.
- Reset asserted during CAP of a read -> no o_rvalid, o_rdata=0, state IDLE after the edge, next command accepted normally.
